// File: rtl/inst_queue.sv
// Fetch-to-decode instruction queue: DEPTH entries of {inst, pc} with wrap-bit pointers.
// Redirect flush empties the queue; out_* read NOP/0 when empty.
module inst_queue #(
   parameter int DEPTH = 4,
   parameter int PTR_W = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_inst,
   input  logic [63:0]      in_pc,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      out_inst,
   output logic [63:0]      out_pc,
   output logic [PTR_W:0]   count
);

   localparam logic [31:0] NOP_INST = 32'h00000013;

   // Handshake: a side transfers on a rising edge only when its valid and ready are both
   // high and flush is low; in_ready is !full and never looks at out_ready.
   logic [95:0]      r_mem [DEPTH];
   logic [PTR_W:0]   r_rd_ptr;
   logic [PTR_W:0]   r_wr_ptr;

   logic             w_empty;
   logic             w_full;
   logic             w_enq;
   logic             w_deq;
   logic [95:0]      w_head;

   assign w_empty   = (r_rd_ptr == r_wr_ptr);
   assign w_full    = (r_rd_ptr[PTR_W-1:0] == r_wr_ptr[PTR_W-1:0]) &&
                      (r_rd_ptr[PTR_W] != r_wr_ptr[PTR_W]);
   assign in_ready  = !w_full;
   assign out_valid = !w_empty;
   assign w_enq     = in_valid && in_ready && !flush;
   assign w_deq     = out_valid && out_ready && !flush;
   assign count     = r_wr_ptr - r_rd_ptr;

   assign w_head    = r_mem[r_rd_ptr[PTR_W-1:0]];
   assign out_inst  = w_empty ? NOP_INST : w_head[95:64];
   assign out_pc    = w_empty ? 64'h0    : w_head[63:0];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
      end else if (flush) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
      end else begin
         if (w_enq) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_deq) r_rd_ptr <= r_rd_ptr + 1'b1;
      end
   end

   // Storage is left unreset; stale contents are hidden by the empty mask.
   always_ff @(posedge clk) begin
      if (w_enq) r_mem[r_wr_ptr[PTR_W-1:0]] <= {in_inst, in_pc};
   end

endmodule

// File: tb/tb_inst_queue.sv
// Directed bench for inst_queue: stimulus pushes expected {inst, pc} entries,
// a negedge monitor pops and compares every delivered head.
module tb_inst_queue;
  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_inst;
  logic [63:0] in_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [63:0] out_pc;
  logic [2:0]  count;

  logic [95:0] exp_q[$];
  int total;
  int bad;

  inst_queue #(.DEPTH(4), .PTR_W(2)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst), .out_pc(out_pc),
    .count(count)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", name, act, req);
    end
  endfunction

  // monitor / scoreboard
  always @(negedge clk) begin
    if (rst && out_valid && out_ready && !flush) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_out: got pc=%h want=none", out_pc);
      end else begin
        logic [95:0] e;
        e = exp_q.pop_front();
        chk("out_pc", out_pc, e[63:0]);
        chk("out_inst", {32'h0, out_inst}, {32'h0, e[95:64]});
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [63:0] pc, input logic [31:0] inst, input bit expect_accept);
    in_valid = 1'b1;
    in_pc    = pc;
    in_inst  = inst;
    if (expect_accept) exp_q.push_back({inst, pc});
  endtask

  task automatic idle_in();
    in_valid = 1'b0;
    in_pc    = 64'h0;
    in_inst  = 32'h0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst = 1'b0; flush = 1'b0; out_ready = 1'b0;
    idle_in();

    // reset state
    #3;
    chk("rst_out_valid", {63'h0, out_valid}, 64'h0);
    chk("rst_in_ready", {63'h0, in_ready}, 64'h1);
    chk("rst_count", {61'h0, count}, 64'h0);
    chk("rst_out_inst", {32'h0, out_inst}, 64'h13);
    chk("rst_out_pc", out_pc, 64'h0);
    @(negedge clk);
    rst = 1'b1;
    tick();

    // fill
    for (int i = 0; i < 4; i++) begin
      offer(64'h80000000 + 64'(4 * i), 32'h00100093 + 32'(i), 1'b1);
      tick();
      chk("fill_count", {61'h0, count}, 64'(i + 1));
    end
    chk("full_in_ready", {63'h0, in_ready}, 64'h0);
    offer(64'h80000010, 32'h00100097, 1'b0);
    tick();
    chk("fifth_count", {61'h0, count}, 64'd4);
    chk("fifth_head", out_pc, 64'h80000000);
    idle_in();

    // drain in order
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("drain_count", {61'h0, count}, 64'(3 - i));
    end
    out_ready = 1'b0;
    chk("drained_valid", {63'h0, out_valid}, 64'h0);
    chk("drained_inst", {32'h0, out_inst}, 64'h13);
    chk("drained_pc", out_pc, 64'h0);

    // streaming with wrap-around
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      offer(64'h80000020 + 64'(4 * i), 32'h00200093 + 32'(i), 1'b1);
      tick();
      chk("stream_count", {61'h0, count}, 64'd1);
      chk("stream_head", out_pc, 64'h80000020 + 64'(4 * i));
    end
    idle_in();
    tick();
    chk("stream_end_count", {61'h0, count}, 64'd0);
    out_ready = 1'b0;

    // full with simultaneous offer and consume
    for (int i = 0; i < 4; i++) begin
      offer(64'h80000040 + 64'(4 * i), 32'h00300093 + 32'(i), 1'b1);
      tick();
    end
    chk("full2_count", {61'h0, count}, 64'd4);
    offer(64'h80000050, 32'h00300097, 1'b1);
    out_ready = 1'b1;
    tick();
    chk("full_deq_only", {61'h0, count}, 64'd3);
    chk("full_deq_ready", {63'h0, in_ready}, 64'h1);
    tick();
    chk("held_accept_count", {61'h0, count}, 64'd3);
    idle_in();
    for (int i = 0; i < 3; i++) tick();
    chk("full2_drain_count", {61'h0, count}, 64'd0);
    out_ready = 1'b0;

    // flush with simultaneous enqueue
    for (int i = 0; i < 3; i++) begin
      offer(64'h80000060 + 64'(4 * i), 32'h00400093 + 32'(i), 1'b1);
      tick();
    end
    chk("preflush_count", {61'h0, count}, 64'd3);
    flush = 1'b1;
    out_ready = 1'b1;
    offer(64'h80000100, 32'h00500093, 1'b0);
    exp_q.delete();
    tick();
    flush = 1'b0;
    out_ready = 1'b0;
    chk("flush_count", {61'h0, count}, 64'd0);
    chk("flush_valid", {63'h0, out_valid}, 64'h0);
    chk("flush_in_ready", {63'h0, in_ready}, 64'h1);
    offer(64'h80000200, 32'h00600093, 1'b1);
    tick();
    idle_in();
    chk("target_valid", {63'h0, out_valid}, 64'h1);
    chk("target_pc", out_pc, 64'h80000200);
    chk("target_count", {61'h0, count}, 64'd1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("target_drained", {61'h0, count}, 64'd0);

    // asynchronous reset mid-stream
    for (int i = 0; i < 2; i++) begin
      offer(64'h80000300 + 64'(4 * i), 32'h00700093 + 32'(i), 1'b1);
      tick();
    end
    idle_in();
    chk("prereset_count", {61'h0, count}, 64'd2);
    #2;
    rst = 1'b0;
    exp_q.delete();
    #1;
    chk("arst_valid", {63'h0, out_valid}, 64'h0);
    chk("arst_count", {61'h0, count}, 64'd0);
    chk("arst_in_ready", {63'h0, in_ready}, 64'h1);
    chk("arst_pc", out_pc, 64'h0);
    @(negedge clk);
    rst = 1'b1;
    tick();
    offer(64'h80000400, 32'h00800093, 1'b1);
    tick();
    idle_in();
    chk("post_rst_count", {61'h0, count}, 64'd1);
    chk("post_rst_pc", out_pc, 64'h80000400);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("post_rst_drained", {61'h0, count}, 64'd0);

    // final report
    tick();
    chk("exp_q_empty", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/inst_queue.md
# inst_queue

Instruction queue between the fetch stage and the decode stage (IDU). Each entry holds one 32-bit instruction and its 64-bit PC. The queue decouples fetch from decode using valid/ready handshakes on both sides. A jump or break redirect flushes it.

## Interface

Parameters:
- DEPTH, 4, number of entries; power of two, minimum 2
- PTR_W, 2, log2(DEPTH); must be consistent with DEPTH

Ports:
- clk  input  1  single clock; all state updates on rising edge
- rst  input  1  reset; asynchronous, active-low; clears all state immediately on assertion
- flush  input  1  redirect from EXU jump (jump_flag) or IDU break; discards all entries
- in_valid  input  1  fetch offers an entry this cycle
- in_ready  output  1  queue can accept an entry; equals !full
- in_inst  input  32  fetched instruction
- in_pc  input  64  PC of in_inst
- out_valid  output  1  head entry present; equals !empty
- out_ready  input  1  decode consumes the head this cycle
- out_inst  output  32  head instruction; 32'h00000013 (NOP) when empty
- out_pc  output  64  head PC; 64'h0 when empty
- count  output  PTR_W+1  number of valid entries, 0..DEPTH

## Operation

- Storage: DEPTH-entry register array of {inst, pc}.
- Pointers: rd_ptr and wr_ptr, each PTR_W+1 bits with an extra wrap bit.
  - empty when rd_ptr == wr_ptr
  - full when low bits are equal and wrap bits differ
  - count = wr_ptr − rd_ptr, modulo 2^(PTR_W+1)
- Enqueue fires when in_valid && in_ready && !flush. It writes mem[wr_ptr[PTR_W-1:0]] and increments wr_ptr.
- Dequeue fires when out_valid && out_ready && !flush. It increments rd_ptr.
- Simultaneous enqueue and dequeue, not full and not empty: both fire and count is unchanged.
- When full, in_ready=0 even if out_ready=1. There is no pass-through on full, so in_ready never depends on out_ready combinationally.
- When empty, nothing is dequeued and there is no bypass: an entry written in cycle N is visible on out_* in cycle N+1.
- Flush has priority over everything:
  - rd_ptr and wr_ptr are set to 0 on the next edge.
  - The in_* entry presented in the same cycle is dropped.
  - Any dequeue in the flush cycle is not counted.
  - Decode must treat out_valid as invalid during the flush cycle. The upstream redirect already kills it.
- Pointer arithmetic wraps naturally at 2^(PTR_W+1). No saturation logic.
- in_valid while in_ready=0: no state change. Fetch must hold its PC; holding is enforced upstream, not here.
- out_ready while empty: ignored.
- out_inst and out_pc are combinational reads of the head entry, muxed to NOP/0 when empty.
- The array has no reset. Only pointers reset; the outputs are masked when empty.

## Timing

- Reset (rst=0, asynchronous): rd_ptr=wr_ptr=0. Output values during reset:
  - out_valid=0
  - in_ready=1
  - count=0
  - out_inst=32'h00000013
  - out_pc=0
- Release of rst is synchronised by the system; the first enqueue can occur on the first rising edge after release.
- Latency, enqueue to out_valid: 1 cycle.
- Throughput: 1 entry/cycle sustained when out_ready=1 and the queue is not full.
- Flush in cycle N: at cycle N+1, count=0, out_valid=0 and in_ready=1.
- Reset asserted mid-operation: all entries are lost immediately, without waiting for a clock edge.
- Entries are delivered in order, with no drops except by flush or reset.

## Test plan

- Reset then fill: rst low → out_valid=0, in_ready=1, count=0.
  - Release rst.
  - Enqueue pc 0x80000000, 0x80000004, 0x80000008, 0x8000000C (inst 0x00100093…) with out_ready=0.
  - Required: count rises 1,2,3,4; in_ready=0 after the 4th; a 5th offer (pc 0x80000010) is not accepted.
- Drain in order: from full, out_ready=1 for 4 cycles.
  - Required: out_pc 0x80000000, …04, …08, …0C in order; count falls to 0; then out_valid=0 and out_inst=0x00000013.
- Streaming with wrap-around: in_valid=1 and out_ready=1 continuously for 10 entries, PCs incrementing by 4.
  - Required: count settles at 1; all 10 PCs appear in order one cycle after entry; pointers wrap past DEPTH without error.
- Full with simultaneous offer and consume: queue full, in_valid=1, out_ready=1.
  - Required: dequeue only, count 4→3; the offered entry is accepted on the following cycle.
- Flush with simultaneous enqueue: 3 entries held, flush=1, in_valid=1 (pc 0x80000100), out_ready=1.
  - Required: next cycle count=0 and out_valid=0; 0x80000100 never appears.
  - Then enqueue jump target 0x80000200 → out_pc=0x80000200 one cycle later.
- Asynchronous reset mid-stream: 2 entries held, rst driven low between clock edges.
  - Required: out_valid=0 and count=0 before the next rising edge; after release the queue accepts new entries normally.
